icache_refill_axi: RTL

- Memory-side responder for the instruction cache refill port.
- Accepts a line-refill request (mem_read_req + mem_addr) and issues one AXI4 INCR read burst for the whole line.
- Assembles the returned beats into a word array and returns it with a one-cycle mem_gnt pulse.
- Sits between the instruction cache and the AXI read channels of the CPU bus interface.

---
 rtl/icache_refill_axi_if.sv | 41 ++++
 rtl/icache_refill_axi.sv | 125 ++++++++++++
 2 files changed

// File: rtl/icache_refill_axi_if.sv
// Bundle between the instruction-cache refill engine and its environment
// (cache request side plus AXI4 AR/R channels).
//   master : refill engine (drives AR channel, rready, mem_gnt, ins, mem_err)
//   slave  : cache + AXI memory (drives request, arready, R channel)
interface icache_refill_axi_if #(
    parameter int OFFSET_LEN = 5
);
    localparam int WORDS = 2 ** (OFFSET_LEN - 2);

    // cache side
    logic        mem_read_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] ins [WORDS];
    logic        mem_err;
    // AXI read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // AXI read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  mem_read_req, mem_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output mem_gnt, ins, mem_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output mem_read_req, mem_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  mem_gnt, ins, mem_err, arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/icache_refill_axi.sv
// Instruction-cache line refill engine.
// Takes a line request, issues one AXI4 INCR read burst covering the whole
// line, gathers the beats into a word array and pulses mem_gnt for one cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - icache_refill_axi_if.master: request/grant/ins/mem_err toward the
//          cache, AR and R channels toward the AXI fabric.
module icache_refill_axi #(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_refill_axi_if.master  bus
);
    localparam int WORDS = 2 ** (OFFSET_LEN - 2);
    localparam int CW    = OFFSET_LEN - 2;
    localparam int AW    = 32 - OFFSET_LEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            ovf_q,   ovf_d;   // all WORDS slots filled, no rlast yet
    logic            err_q,   err_d;
    logic [31:0]     ins_q [WORDS];
    logic [31:0]     ins_d [WORDS];

    logic            last_slot;
    logic            bad_resp;

    assign last_slot = (cnt_q == {CW{1'b1}});
    assign bad_resp  = (bus.rresp != 2'b00);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        for (int i = 0; i < WORDS; i++) ins_d[i] = ins_q[i];

        case (state_q)
            S_IDLE: begin
                if (bus.mem_read_req) begin
                    addr_d  = bus.mem_addr[31:OFFSET_LEN];
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.arready) state_d = S_DATA;
            end
            S_DATA: begin
                // rready is 1 throughout DATA, so rvalid alone marks a beat
                if (bus.rvalid) begin
                    // once the line is full, further beats are dropped
                    if (!ovf_q) ins_d[cnt_q] = bus.rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (bus.rlast) begin
                        // rlast must coincide with the final slot
                        err_d   = err_q | bad_resp | ovf_q | !last_slot;
                        state_d = S_DONE;
                    end else begin
                        // line full without rlast: burst is already malformed
                        if (last_slot) ovf_d = 1'b1;
                        err_d = err_q | bad_resp | ovf_q | last_slot;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) ins_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            for (int i = 0; i < WORDS; i++) ins_q[i] <= ins_d[i];
        end
    end

    // AR fields come straight from captured state, so they are stable
    // for the whole time arvalid is high.
    assign bus.arid    = AXI_ID;
    assign bus.araddr  = {addr_q, {OFFSET_LEN{1'b0}}};
    assign bus.arlen   = 8'(WORDS - 1);
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = (state_q == S_ADDR);
    assign bus.rready  = (state_q == S_DATA);
    assign bus.mem_gnt = (state_q == S_DONE);
    assign bus.mem_err = (state_q == S_DONE) && err_q;

    for (genvar g = 0; g < WORDS; g++) begin : g_ins
        assign bus.ins[g] = ins_q[g];
    end

    // rid and the line-offset bits of mem_addr carry no information here
    logic unused_in;
    assign unused_in = ^{bus.rid, bus.mem_addr[OFFSET_LEN-1:0]};

endmodule
